iris_feeder: RTL and testbench

Request-side driver for the Iris classifier top (`Iris_net`). It buffers labelled feature vectors from a host stream and presents each one on X1..X4 while holding Run. It then waits for Ready_NN_arg[3] (Ready_arg), captures the one-hot class Yc and returns it on a result handshake together with a correct/incorrect flag. Two running counters (samples processed, samples classified correctly) provide an on-chip accuracy measurement.

---
 rtl/iris_pkg.sv | 35 +++
 rtl/sample_fifo.sv | 61 ++++++
 rtl/iris_feeder.sv | 191 +++++++++++++++++++
 tb/tb_iris_feeder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iris_pkg.sv
// Shared types and constants for the Iris classifier request driver.
package iris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESULT
  } state_e;

  localparam logic [2:0] SETOSA     = 3'b001;
  localparam logic [2:0] VERSICOLOR = 3'b010;
  localparam logic [2:0] VIRGINICA  = 3'b100;

  localparam int unsigned IRIS_DW = 8;

  typedef struct packed {
    logic [2:0]         label;
    logic [IRIS_DW-1:0] x4;
    logic [IRIS_DW-1:0] x3;
    logic [IRIS_DW-1:0] x2;
    logic [IRIS_DW-1:0] x1;
  } sample_t;

  typedef struct packed {
    logic [2:0] cls;
    logic       correct;
    logic       timeout;
  } result_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy counter; pointers wrap naturally at a
// power-of-two depth.
module sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/iris_feeder.sv
// Feeds buffered labelled samples to the Iris network, captures each class
// result and keeps running totals for an on-chip accuracy measurement.
module iris_feeder
  import iris_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  En,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_X1,
  input  logic [DATA_WIDTH-1:0] in_X2,
  input  logic [DATA_WIDTH-1:0] in_X3,
  input  logic [DATA_WIDTH-1:0] in_X4,
  input  logic [2:0]            in_label,
  output logic [DATA_WIDTH-1:0] X1,
  output logic [DATA_WIDTH-1:0] X2,
  output logic [DATA_WIDTH-1:0] X3,
  output logic [DATA_WIDTH-1:0] X4,
  output logic                  Run,
  input  logic [2:0]            Yc,
  input  logic [3:0]            Ready_NN_arg,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2:0]            res_class,
  output logic                  res_correct,
  output logic                  res_timeout,
  output logic [15:0]           total_cnt,
  output logic [15:0]           correct_cnt,
  output logic                  busy
);

  localparam int unsigned EW = 3 + 4 * DATA_WIDTH;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [2:0]            label;
    logic [DATA_WIDTH-1:0] x4;
    logic [DATA_WIDTH-1:0] x3;
    logic [DATA_WIDTH-1:0] x2;
    logic [DATA_WIDTH-1:0] x1;
  } entry_t;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
  logic [2:0]            label_q, label_d;
  logic                  run_q, run_d;
  logic                  res_valid_q, res_valid_d;
  result_t               res_q, res_d;
  logic [15:0]           total_q, total_d;
  logic [15:0]           correct_q, correct_d;

  entry_t fifo_head;
  logic   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic   ready_unused;

  // Only the classification-valid bit of the network ready bus matters here.
  assign ready_unused = ^Ready_NN_arg[2:0];

  assign fifo_push = in_valid && !fifo_full && En;

  sample_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata({in_label, in_X4, in_X3, in_X2, in_X1}),
    .pop  (fifo_pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    x4_d        = x4_q;
    label_d     = label_q;
    run_d       = run_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    total_d     = total_q;
    correct_d   = correct_q;
    fifo_pop    = 1'b0;
    if (En) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            x1_d     = fifo_head.x1;
            x2_d     = fifo_head.x2;
            x3_d     = fifo_head.x3;
            x4_d     = fifo_head.x4;
            label_d  = fifo_head.label;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          timer_d = '0;
          run_d   = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          // Ready wins over a timeout landing on the same cycle.
          if (Ready_NN_arg[3]) begin
            res_d.cls     = Yc;
            res_d.correct = (Yc == label_q);
            res_d.timeout = 1'b0;
            run_d         = 1'b0;
            res_valid_d   = 1'b1;
            state_d       = RESULT;
          end else if (timer_q == TIMER_LAST) begin
            res_d.cls     = 3'b000;
            res_d.correct = 1'b0;
            res_d.timeout = 1'b1;
            run_d         = 1'b0;
            res_valid_d   = 1'b1;
            state_d       = RESULT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            total_d     = sat_inc16(total_q);
            if (res_q.correct) correct_d = sat_inc16(correct_q);
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      x4_q        <= '0;
      label_q     <= '0;
      run_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      total_q     <= '0;
      correct_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      x4_q        <= x4_d;
      label_q     <= label_d;
      run_q       <= run_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      total_q     <= total_d;
      correct_q   <= correct_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign X1          = x1_q;
  assign X2          = x2_q;
  assign X3          = x3_q;
  assign X4          = x4_q;
  assign Run         = run_q;
  assign res_valid   = res_valid_q;
  assign res_class   = res_q.cls;
  assign res_correct = res_q.correct;
  assign res_timeout = res_q.timeout;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_iris_feeder.sv
// Bench for iris_feeder: stub network plus queue-based result/counter model.
module tb_iris_feeder;
  import iris_pkg::*;

  localparam int TMO = 8;

  logic       clk, rst, En, in_valid, in_ready, Run, res_valid, res_ready;
  logic [7:0] in_X1, in_X2, in_X3, in_X4, X1, X2, X3, X4;
  logic [2:0] in_label, Yc, res_class;
  logic [3:0] Ready_NN_arg;
  logic       res_correct, res_timeout, busy;
  logic [15:0] total_cnt, correct_cnt;

  iris_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .En(En), .in_valid(in_valid), .in_ready(in_ready),
    .in_X1(in_X1), .in_X2(in_X2), .in_X3(in_X3), .in_X4(in_X4), .in_label(in_label),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4), .Run(Run), .Yc(Yc), .Ready_NN_arg(Ready_NN_arg),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_correct(res_correct), .res_timeout(res_timeout), .total_cnt(total_cnt),
    .correct_cnt(correct_cnt), .busy(busy)
  );

  typedef struct {
    sample_t    s;
    logic [2:0] yc;
    int         lat;
  } plan_t;

  plan_t net_q[$];
  plan_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    en_mode = 1;  // 0 low, 1 high, 2 random
  int    rr_mode = 0;  // 0 low, 1 high, 2 random
  logic [15:0] m_total = 0, m_correct = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2:0] cls_of(input int i);
    case (i)
      0:       return SETOSA;
      1:       return VERSICOLOR;
      default: return VIRGINICA;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int limit, output int n);
    n = 0;
    while (((sel == 0) ? Run : res_valid) !== val) begin
      if (n >= limit) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles", name, limit);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic push_sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [2:0] lab, input logic [2:0] yc,
                             input int lat, output int waits);
    plan_t p;
    p.s.x1 = a; p.s.x2 = b; p.s.x3 = c; p.s.x4 = d; p.s.label = lab;
    p.yc = yc; p.lat = lat;
    waits = 0;
    in_valid = 1'b1;
    in_X1 = a; in_X2 = b; in_X3 = c; in_X4 = d; in_label = lab;
    while (!(in_ready && En)) begin
      if (waits >= 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL push_accept: in_ready never rose");
        in_valid = 1'b0;
        return;
      end
      tick();
      waits++;
    end
    net_q.push_back(p);
    exp_q.push_back(p);
    tick();
    in_valid = 1'b0;
  endtask

  // En / res_ready driver, one cycle ahead of the main stimulus.
  initial begin
    En = 1'b1;
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      En        = (en_mode == 2) ? ($urandom_range(0, 4) != 0) : (en_mode == 1);
      res_ready = (rr_mode == 2) ? $urandom_range(0, 1) : (rr_mode == 1);
    end
  end

  // Stub network and per-cycle model comparison, on the falling edge.
  initial begin
    plan_t cur, e;
    logic  run_prev = 1'b0;
    logic  active = 1'b0;
    int    k = 0;
    logic  ok;
    Ready_NN_arg = '0;
    Yc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        net_q.delete();
        exp_q.delete();
        m_total = 0;
        m_correct = 0;
        active = 1'b0;
        run_prev = 1'b0;
        Ready_NN_arg = '0;
        continue;
      end
      check("total_cnt", total_cnt, m_total);
      check("correct_cnt", correct_cnt, m_correct);
      if (Run && res_valid) check("run_vs_res_valid", 1, 0);
      if (Run && !run_prev) begin
        if (net_q.size() == 0) begin
          check("run_without_sample", 1, 0);
          active = 1'b0;
        end else begin
          cur = net_q.pop_front();
          active = 1'b1;
          k = 0;
        end
      end
      if (!Run) active = 1'b0;
      Ready_NN_arg[2:0] = 3'($urandom);
      if (Run && active) begin
        check("x_during_run", {X4, X3, X2, X1}, {cur.s.x4, cur.s.x3, cur.s.x2, cur.s.x1});
        Ready_NN_arg[3] = (k + 1 >= cur.lat);
        Yc = Ready_NN_arg[3] ? cur.yc : 3'($urandom);
        if (En) k++;
      end else begin
        Ready_NN_arg[3] = 1'b0;
        Yc = 3'($urandom);
      end
      run_prev = Run;
      if (res_valid && res_ready && En) begin
        if (exp_q.size() == 0) begin
          check("result_without_sample", 1, 0);
        end else begin
          e = exp_q.pop_front();
          ok = (e.lat <= TMO);
          check("res_timeout", res_timeout, !ok);
          check("res_class", res_class, ok ? e.yc : 3'b000);
          check("res_correct", res_correct, ok && (e.yc == e.s.label));
          m_total = (m_total == 16'hFFFF) ? m_total : m_total + 1;
          if (ok && (e.yc == e.s.label) && m_correct != 16'hFFFF) m_correct = m_correct + 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w, wsum, lat, r;
    logic [2:0] lab, yc;
    rst = 1'b1;
    in_valid = 1'b0;
    in_X1 = '0; in_X2 = '0; in_X3 = '0; in_X4 = '0; in_label = '0;
    repeat (3) tick();
    check("rst_x", {X4, X3, X2, X1}, 0);
    check("rst_run", Run, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res", {res_class, res_correct, res_timeout}, 0);
    check("rst_cnt", {total_cnt, correct_cnt}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single correctly classified sample, ready 5 cycles after Run.
    push_sample(8'd10, 8'd20, 8'd30, 8'd40, SETOSA, SETOSA, 5, w);
    wait_sig("run_rise", 0, 1'b1, 10, n);
    check("run_rise_latency", n, 2);
    wait_sig("ready_result", 1, 1'b1, 20, n);
    check("ready_latency", n, 5);
    check("t1_run_low", Run, 0);
    check("t1_x", {X1, X2, X3, X4}, {8'd10, 8'd20, 8'd30, 8'd40});
    check("t1_res", {res_class, res_correct, res_timeout}, {3'b001, 1'b1, 1'b0});
    rr_mode = 1;
    wait_sig("t1_accept", 1, 1'b0, 10, n);
    rr_mode = 0;
    check("t1_total", total_cnt, 1);
    check("t1_correct", correct_cnt, 1);

    // Network never answers: timeout after exactly TMO cycles of Run.
    push_sample(8'd1, 8'd2, 8'd3, 8'd4, VERSICOLOR, VERSICOLOR, 1000, w);
    wait_sig("t2_run", 0, 1'b1, 10, n);
    wait_sig("t2_result", 1, 1'b1, 40, n);
    check("timeout_latency", n, TMO);
    check("t2_res", {res_class, res_correct, res_timeout}, {3'b000, 1'b0, 1'b1});
    check("t2_run_low", Run, 0);
    rr_mode = 1;
    wait_sig("t2_accept", 1, 1'b0, 10, n);
    rr_mode = 0;
    check("t2_cnt", {total_cnt, correct_cnt}, {16'd2, 16'd1});

    // Misclassification.
    push_sample(8'd5, 8'd6, 8'd7, 8'd8, VERSICOLOR, VIRGINICA, 3, w);
    wait_sig("t3_result", 1, 1'b1, 40, n);
    check("t3_res", {res_class, res_correct, res_timeout}, {3'b100, 1'b0, 1'b0});
    rr_mode = 1;
    wait_sig("t3_accept", 1, 1'b0, 10, n);
    rr_mode = 0;
    check("t3_cnt", {total_cnt, correct_cnt}, {16'd3, 16'd1});

    // En held low for 10 cycles in WAIT must not let the timeout fire.
    push_sample(8'd9, 8'd9, 8'd9, 8'd9, VIRGINICA, VIRGINICA, 6, w);
    wait_sig("t4_run", 0, 1'b1, 10, n);
    repeat (3) tick();
    en_mode = 0;
    repeat (11) tick();
    check("t4_frozen", {Run, res_valid}, 2'b10);
    en_mode = 1;
    wait_sig("t4_result", 1, 1'b1, 20, n);
    check("t4_res", {res_class, res_correct, res_timeout}, {3'b100, 1'b1, 1'b0});
    rr_mode = 1;
    wait_sig("t4_accept", 1, 1'b0, 10, n);
    rr_mode = 0;
    check("t4_cnt", {total_cnt, correct_cnt}, {16'd4, 16'd2});

    // Back-to-back pushes fill the buffer while the first result is held.
    wsum = 0;
    for (int i = 0; i < 5; i++) begin
      push_sample(8'(i * 3), 8'(i * 5), 8'(i * 7), 8'(i * 11), cls_of(i % 3), cls_of(i % 3),
                  $urandom_range(1, 4), w);
      wsum += w;
    end
    check("b2b_no_stall", wsum, 0);
    check("b2b_full", in_ready, 0);
    check("b2b_busy", busy, 1);
    rr_mode = 1;
    push_sample(8'd99, 8'd98, 8'd97, 8'd96, VIRGINICA, VIRGINICA, 2, w);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
    check("b2b_drained", exp_q.size(), 0);
    rr_mode = 0;
    tick();
    check("b2b_cnt", {total_cnt, correct_cnt}, {16'd10, 16'd8});

    // Reset mid-sample with two more queued.
    push_sample(8'd1, 8'd1, 8'd1, 8'd1, SETOSA, SETOSA, 1000, w);
    push_sample(8'd2, 8'd2, 8'd2, 8'd2, SETOSA, SETOSA, 1000, w);
    push_sample(8'd3, 8'd3, 8'd3, 8'd3, SETOSA, SETOSA, 1000, w);
    wait_sig("t6_run", 0, 1'b1, 10, n);
    rst = 1'b1;
    tick();
    check("t6_run", Run, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", {total_cnt, correct_cnt}, 0);
    check("t6_in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (4) tick();
    check("t6_fifo_flushed", {busy, Run}, 0);

    // Randomized traffic with random En and result back-pressure.
    en_mode = 2;
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      lab = cls_of($urandom_range(0, 2));
      yc  = ($urandom_range(0, 1) != 0) ? lab : cls_of($urandom_range(0, 2));
      r   = $urandom_range(0, 9);
      lat = (r == 0) ? 1000 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : $urandom_range(1, TMO);
      push_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), lab, yc, lat, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
    end
    en_mode = 1;
    rr_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
    check("rand_drained", exp_q.size(), 0);
    repeat (3) tick();
    check("rand_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
